// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller: run-state encoding and
// default widths used by cpu_run_ctrl and cpu_run_watch.
package cpu_run_pkg;

  typedef logic [1:0] run_state_t;

  localparam run_state_t ST_IDLE = 2'd0;
  localparam run_state_t ST_RUN  = 2'd1;
  localparam run_state_t ST_DONE = 2'd2;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_PC_W       = 16;
  localparam int DEF_NUM_WATCH  = 2;
  localparam int DEF_CYC_W      = 16;
  localparam int DEF_HIT_W      = 8;
  localparam int DEF_MAX_CYCLES = 1000;

endpackage

// File: rtl/cpu_run_watch.sv
// One PC watch channel: compares the live PC against its watch address and,
// on every enabled cycle that matches, captures the ALU result and bumps a
// saturating hit counter. Cleared when a new run starts.
module cpu_run_watch #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int HIT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   watch_pc,
  input  logic [DATA_W-1:0] result,
  output logic [HIT_W-1:0]  hit_count,
  output logic [DATA_W-1:0] watch_data
);

  logic match;

  // Hit counter sticks at all-ones instead of wrapping.
  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    return (&v) ? v : v + HIT_W'(1);
  endfunction

  assign match = (pc == watch_pc);

  // Capture register and hit counter; clear on run entry, update on enabled match.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      watch_data <= '0;
    end else if (clear) begin
      hit_count  <= '0;
      watch_data <= '0;
    end else if (en && match) begin
      hit_count  <= sat_inc(hit_count);
      watch_data <= result;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: gates the processor clock-enable over a run that ends
// when the PC passes stop_pc, when MAX_CYCLES enabled cycles have elapsed,
// or on abort. Counts enabled cycles and drives NUM_WATCH PC watch channels.
// Optional single-step gating is selected by the macro CPU_RUN_CTRL_STEP_EN.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PC_W       = DEF_PC_W,
  parameter int NUM_WATCH  = DEF_NUM_WATCH,
  parameter int CYC_W      = DEF_CYC_W,
  parameter int HIT_W      = DEF_HIT_W,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [PC_W-1:0]             stop_pc,
  input  logic [NUM_WATCH*PC_W-1:0]   watch_pc,
  input  logic [PC_W-1:0]             pc,
  input  logic [DATA_W-1:0]           result,
  input  logic                        step_mode,
  input  logic                        step,
  output logic                        cpu_en,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout,
  output logic [CYC_W-1:0]            cycle_count,
  output logic [NUM_WATCH*HIT_W-1:0]  hit_count,
  output logic [NUM_WATCH*DATA_W-1:0] watch_data
);

  // Count value at which the enabled cycle in flight is the last one allowed.
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);

  run_state_t state;
  logic       stop_hit;
  logic       step_gate;
  logic       enter_run;
  logic       last_cycle;

  // The processor may run only up to and including stop_pc.
  assign stop_hit = (pc > stop_pc);

`ifdef CPU_RUN_CTRL_STEP_EN
  // In step mode each cycle with step high is exactly one enabled cycle.
  assign step_gate = !step_mode || step;
`else
  logic unused_step;
  assign unused_step = step_mode ^ step;
  assign step_gate   = 1'b1;
`endif

  assign cpu_en     = (state == ST_RUN) && !stop_hit && !abort && step_gate;
  assign enter_run  = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign last_cycle = cpu_en && (cycle_count == CYC_LAST);

  // Status outputs decode only the registered state, never the inputs.
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Run FSM with cycle counter and timeout flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_RUN;
            cycle_count <= '0;
            timeout     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort || stop_hit) begin
            state <= ST_DONE;
          end else if (cpu_en) begin
            cycle_count <= cycle_count + CYC_W'(1);
            if (last_cycle) begin
              timeout <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // One watch channel per watch address; all matching channels update together.
  for (genvar i = 0; i < NUM_WATCH; i++) begin : g_watch
    cpu_run_watch #(
      .DATA_W (DATA_W),
      .PC_W   (PC_W),
      .HIT_W  (HIT_W)
    ) u_watch (
      .clock      (clock),
      .reset      (reset),
      .clear      (enter_run),
      .en         (cpu_en),
      .pc         (pc),
      .watch_pc   (watch_pc[i*PC_W +: PC_W]),
      .result     (result),
      .hit_count  (hit_count[i*HIT_W +: HIT_W]),
      .watch_data (watch_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: two instances (8-bit and 3-bit hit
// counters, both MAX_CYCLES=10) share directed stimulus and are compared
// every cycle against a run-rule model, plus literal checkpoints.
module tb_cpu_run_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] stop_pc;
  logic [31:0] watch_pc;
  logic [15:0] pc;
  logic [15:0] result;
  logic        step_mode;
  logic        step;

  logic        cpu_en_a, busy_a, done_a, timeout_a;
  logic [15:0] cycle_a;
  logic [15:0] hit_a;
  logic [31:0] wd_a;
  logic        cpu_en_b, busy_b, done_b, timeout_b;
  logic [15:0] cycle_b;
  logic [5:0]  hit_b;
  logic [31:0] wd_b;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;
  bit follow = 0;
  int en_cnt = 0;
  logic [15:0] rbias = 16'h0;

  cpu_run_ctrl #(.MAX_CYCLES(10)) dut_a (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .stop_pc(stop_pc), .watch_pc(watch_pc), .pc(pc), .result(result),
    .step_mode(step_mode), .step(step),
    .cpu_en(cpu_en_a), .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .cycle_count(cycle_a), .hit_count(hit_a), .watch_data(wd_a)
  );

  cpu_run_ctrl #(.MAX_CYCLES(10), .HIT_W(3)) dut_b (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .stop_pc(stop_pc), .watch_pc(watch_pc), .pc(pc), .result(result),
    .step_mode(step_mode), .step(step),
    .cpu_en(cpu_en_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .cycle_count(cycle_b), .hit_count(hit_b), .watch_data(wd_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model of the run rules: is a run active, has one finished, what was counted.
  typedef struct {
    bit          running;
    bit          finished;
    int          cyc;
    int          hit[2];
    logic [15:0] wd[2];
    bit          to;
  } mst_t;

  mst_t ma, mb;

  function automatic mst_t mclear();
    mst_t m;
    m.running = 0; m.finished = 0; m.cyc = 0; m.to = 0;
    for (int i = 0; i < 2; i++) begin m.hit[i] = 0; m.wd[i] = '0; end
    return m;
  endfunction

  function automatic bit gate();
`ifdef CPU_RUN_CTRL_STEP_EN
    return !step_mode || step;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [15:0] wpc(input int i);
    return watch_pc[i*16 +: 16];
  endfunction

  function automatic bit exp_en(input mst_t m);
    return m.running && !(pc > stop_pc) && !abort && gate();
  endfunction

  function automatic mst_t mstep(input mst_t m0, input int hmax);
    mst_t m = m0;
    if (!m.running) begin
      if (start) begin
        m = mclear();
        m.running = 1;
      end
    end else if (abort || (pc > stop_pc)) begin
      m.running = 0; m.finished = 1;
    end else if (gate()) begin
      m.cyc = m.cyc + 1;
      for (int i = 0; i < 2; i++)
        if (pc == wpc(i)) begin
          m.wd[i] = result;
          if (m.hit[i] < hmax) m.hit[i] = m.hit[i] + 1;
        end
      if (m.cyc == 10) begin
        m.to = 1; m.running = 0; m.finished = 1;
      end
    end
    return m;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ma <= mclear();
      mb <= mclear();
    end else begin
      ma <= mstep(ma, 255);
      mb <= mstep(mb, 7);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      check("a.cpu_en", 32'(cpu_en_a), 32'(exp_en(ma)));
      check("a.busy", 32'(busy_a), 32'(ma.running));
      check("a.done", 32'(done_a), 32'(ma.finished));
      check("a.timeout", 32'(timeout_a), 32'(ma.to));
      check("a.cycle", 32'(cycle_a), 32'(ma.cyc));
      check("b.cpu_en", 32'(cpu_en_b), 32'(exp_en(mb)));
      check("b.done", 32'(done_b), 32'(mb.finished));
      check("b.timeout", 32'(timeout_b), 32'(mb.to));
      check("b.cycle", 32'(cycle_b), 32'(mb.cyc));
      for (int i = 0; i < 2; i++) begin
        check($sformatf("a.hit%0d", i), 32'(hit_a[i*8 +: 8]), 32'(ma.hit[i]));
        check($sformatf("a.wd%0d", i), 32'(wd_a[i*16 +: 16]), 32'(ma.wd[i]));
        check($sformatf("b.hit%0d", i), 32'(hit_b[i*3 +: 3]), 32'(mb.hit[i]));
        check($sformatf("b.wd%0d", i), 32'(wd_b[i*16 +: 16]), 32'(mb.wd[i]));
      end
    end
  end

  // One clock: sample enable, cross the edge, then advance the fake processor.
  task automatic tick();
    bit en;
    #1;
    en = cpu_en_a;
    if (en) en_cnt++;
    @(posedge clock);
    #2;
    if (follow && en) pc = pc + 16'd1;
    result = (pc ^ 16'h0002) + rbias;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin
      tick();
      n++;
    end
    check("wait_done", 32'(done_a), 32'd1);
  endtask

  initial begin
    reset = 0; start = 0; abort = 0; step_mode = 0; step = 0;
    stop_pc = 16'd7; watch_pc = {16'd3, 16'd7}; pc = 16'd0; result = 16'h0002;
    #1 reset = 1;
    #1;
    check("rst.busy", 32'(busy_a), 32'd0);
    check("rst.done", 32'(done_a), 32'd0);
    check("rst.cycle", 32'(cycle_a), 32'd0);
    check("rst.cpu_en", 32'(cpu_en_a), 32'd0);
    check("rst.hit", 32'(hit_a), 32'd0);
    @(posedge clock);
    #2 reset = 0;
    chk_on = 1;

    // Free run from pc 0 to just beyond stop_pc 7.
    pc = 16'd0; follow = 1; result = pc ^ 16'h0002;
    start = 1; tick(); start = 0;
    en_cnt = 0;
    run_until_done(50);
    check("run.en_cycles", 32'(en_cnt), 32'd8);
    check("run.cycle", 32'(cycle_a), 32'd8);
    check("run.timeout", 32'(timeout_a), 32'd0);
    check("run.pc_frozen", 32'(pc), 32'd8);
    check("run.wd0", 32'(wd_a[15:0]), 32'h0005);
    check("run.hit0", 32'(hit_a[7:0]), 32'd1);
    check("run.hit1", 32'(hit_a[15:8]), 32'd1);
    check("run.wd1", 32'(wd_a[31:16]), 32'h0001);

    // Timeout: pc held at 2, both channels watching it; start held in RUN is ignored.
    follow = 0; pc = 16'd2; rbias = 16'h0100; result = (pc ^ 16'h0002) + rbias;
    watch_pc = {16'd2, 16'd2};
    start = 1; tick(); tick(); tick(); tick(); start = 0;
    run_until_done(30);
    tick(); tick();
    check("to.cycle", 32'(cycle_a), 32'd10);
    check("to.timeout_a", 32'(timeout_a), 32'd1);
    check("to.timeout_b", 32'(timeout_b), 32'd1);
    check("to.hit_a0", 32'(hit_a[7:0]), 32'd10);
    check("to.hit_a1", 32'(hit_a[15:8]), 32'd10);
    check("to.hit_b0", 32'(hit_b[2:0]), 32'd7);
    check("to.wd_b1", 32'(wd_b[31:16]), 32'h0100);

    // Abort on the 4th RUN cycle, then restart from DONE.
    rbias = 16'h0; watch_pc = {16'd3, 16'd7}; pc = 16'd0; follow = 1;
    result = pc ^ 16'h0002;
    start = 1; tick(); start = 0;
    #1;
    check("ab.timeout_clr", 32'(timeout_a), 32'd0);
    check("ab.cycle_clr", 32'(cycle_a), 32'd0);
    check("ab.hit_clr", 32'(hit_a), 32'd0);
    tick(); tick(); tick();
    abort = 1;
    #1;
    check("ab.cpu_en", 32'(cpu_en_a), 32'd0);
    tick(); abort = 0;
    check("ab.done", 32'(done_a), 32'd1);
    check("ab.cycle", 32'(cycle_a), 32'd3);
    check("ab.timeout", 32'(timeout_a), 32'd0);
    abort = 1; tick(); abort = 0;
    check("ab.ignored", 32'(done_a), 32'd1);
    start = 1; tick(); start = 0;
    #1;
    check("re.cycle", 32'(cycle_a), 32'd0);
    check("re.busy", 32'(busy_a), 32'd1);
    run_until_done(30);
    check("re.cycle_end", 32'(cycle_a), 32'd5);
    check("re.hit0", 32'(hit_a[7:0]), 32'd1);
    check("re.hit1", 32'(hit_a[15:8]), 32'd1);

    // Single step: three step pulses over nine cycles, then abort.
    pc = 16'd0; stop_pc = 16'd20; follow = 1; step_mode = 1;
    result = pc ^ 16'h0002;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 9; k++) begin
      step = (k % 3 == 0);
      tick();
    end
    step = 0;
    abort = 1; tick(); abort = 0;
`ifdef CPU_RUN_CTRL_STEP_EN
    check("step.cycle", 32'(cycle_a), 32'd3);
`else
    check("step.cycle", 32'(cycle_a), 32'd9);
`endif
    check("step.done", 32'(done_a), 32'd1);
    step_mode = 0;

    // Reset asserted in the 5th cycle of a run.
    pc = 16'd0; stop_pc = 16'd7; watch_pc = {16'd1, 16'd2};
    result = pc ^ 16'h0002;
    start = 1; tick(); start = 0;
    tick(); tick(); tick(); tick();
    check("mr.busy_before", 32'(busy_a), 32'd1);
    #1 reset = 1;
    #1;
    check("mr.busy", 32'(busy_a), 32'd0);
    check("mr.cpu_en", 32'(cpu_en_a), 32'd0);
    check("mr.cycle", 32'(cycle_a), 32'd0);
    check("mr.hit", 32'(hit_a), 32'd0);
    check("mr.wd", wd_a, 32'd0);
    check("mr.done", 32'(done_a), 32'd0);
    tick();
    reset = 0;
    tick();
    check("mr.idle", 32'(busy_a), 32'd0);
    check("mr.cycle_after", 32'(cycle_a), 32'd0);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath/result width.
REQ-002 SHALL have parameter PC_W, default 16, program-counter width.
REQ-003 SHALL have parameter NUM_WATCH, default 2, number of PC watch channels (1..8).
REQ-004 SHALL have parameter CYC_W, default 16, cycle-counter width.
REQ-005 SHALL have parameter HIT_W, default 8, per-channel hit-counter width.
REQ-006 SHALL have parameter MAX_CYCLES, default 1000, timeout limit in enabled cycles (< 2**CYC_W).
REQ-007 SHALL have ports: clock  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  begin a run; sampled in IDLE or DONE only.
REQ-010 abort  in  1  end a run immediately; sampled in RUN only.
REQ-011 stop_pc  in  PC_W  last PC allowed to execute.
REQ-012 watch_pc  in  NUM_WATCH*PC_W  watch address per channel; channel i at bits [i*PC_W +: PC_W].
REQ-013 pc  in  PC_W  processor's current program counter.
REQ-014 result  in  DATA_W  processor ALU result for the current instruction.
REQ-015 step_mode  in  1  single-step select.
REQ-016 step  in  1  single-step pulse.
REQ-017 cpu_en  out  1  processor clock-enable.
REQ-018 busy  out  1  high in RUN.
REQ-019 done  out  1  high in DONE.
REQ-020 timeout  out  1  run ended by MAX_CYCLES.
REQ-021 cycle_count  out  CYC_W  enabled cycles in current/last run.
REQ-022 hit_count  out  NUM_WATCH*HIT_W  per-channel watch hits.
REQ-023 watch_data  out  NUM_WATCH*DATA_W  per-channel last captured result.

Function
REQ-024 FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN and DONE->RUN on start; RUN->DONE on stop, timeout or abort; no other transitions.
REQ-025 Entering RUN SHALL clear cycle_count, all hit_count, all watch_data and timeout in the same edge.
REQ-026 "stop" = pc > stop_pc, unsigned compare.
REQ-027 cpu_en SHALL be combinational: state==RUN and not stop and not abort and step-gate true (REQ-040).
REQ-028 An enabled cycle (cpu_en=1) SHALL increment cycle_count by 1.
REQ-029 In an enabled cycle, each channel i with pc==watch_pc[i] SHALL load result into watch_data[i] and increment hit_count[i], saturating at 2**HIT_W-1.
REQ-030 Several channels matching the same pc SHALL all update in that cycle.
REQ-031 A cycle in RUN with stop=1 SHALL move to DONE without counting or capturing; the processor is therefore frozen at the first PC beyond stop_pc.
REQ-032 An enabled cycle bringing cycle_count to MAX_CYCLES SHALL count and capture normally, set timeout=1 and move to DONE.
REQ-033 stop and timeout conditions are exclusive by REQ-027; abort SHALL take priority over both and leave timeout=0.
REQ-034 start asserted in RUN SHALL be ignored; abort outside RUN SHALL be ignored.
REQ-035 In DONE, all counters, watch_data and timeout SHALL hold until the next start.
REQ-036 busy, done, timeout SHALL be registered state decodes (no combinational path from inputs).

Reset
REQ-037 reset SHALL force state IDLE, cycle_count=0, hit_count=0, watch_data=0, timeout=0 at once, independent of clock.
REQ-038 Reset asserted mid-RUN SHALL drop cpu_en and busy to 0 in the same cycle; no counter update on the following edge.

Configuration
REQ-039 Macro CPU_RUN_CTRL_STEP_EN SHALL select single-step support.
REQ-040 With CPU_RUN_CTRL_STEP_EN defined, step-gate = (!step_mode || step); each step-high cycle is one enabled cycle.
REQ-041 Without it, step-gate is constant 1; step_mode and step remain ports and are ignored.

Structure
REQ-042 Package cpu_run_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default widths.
REQ-043 One sub-module cpu_run_watch (comparator, hit counter, capture register) SHALL be instantiated NUM_WATCH times via generate.

Verification
REQ-044 stop_pc=7, pc steps 0..8, start pulse -> cpu_en high 8 cycles, DONE with cycle_count=8, timeout=0.
REQ-045 watch_pc[0]=7, result=16'h0005 at pc 7 -> watch_data[0]=16'h0005, hit_count[0]=1; watch_pc[1]=3 -> hit_count[1]=1.
REQ-046 MAX_CYCLES=10, pc held at 2, stop_pc=7 -> DONE after 10 enabled cycles, timeout=1, hit_count for pc 2 =10; HIT_W=3 variant saturates at 7.
REQ-047 abort on 4th RUN cycle -> cpu_en 0 that cycle, DONE, cycle_count=3, timeout=0; start in DONE restarts with counters cleared.
REQ-048 reset asserted on cycle 5 of a run -> IDLE, all outputs 0 immediately.
REQ-049 STEP_EN defined, step_mode=1, 3 step pulses -> cycle_count=3; macro undefined -> step ignored, free-run.
